// File: rtl/dpi_mem_bridge_pkg.sv
// Shared widths and physical-memory access routines for the DPI memory bridge
// and the simulation environment; the memory routines are declared only here.
package dpi_mem_bridge_pkg;

    localparam int ADDR_W     = 64;
    localparam int DATA_W     = 64;
    localparam int MASK_W     = DATA_W / 8;
    localparam int PMEM_WORDS = 256;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [MASK_W-1:0] mask_t;
    typedef logic [7:0]        pidx_t;

    // Word-addressed backing store of the environment, plus call bookkeeping
    data_t       pmem [PMEM_WORDS];
    int unsigned pmem_rd_cnt;
    int unsigned pmem_wr_cnt;
    addr_t       pmem_last_addr;
    mask_t       pmem_last_mask;

    function automatic addr_t word_align(input addr_t a);
        return {a[ADDR_W-1:3], 3'b000};
    endfunction

    function automatic pidx_t pmem_idx(input addr_t a);
        return a[10:3];
    endfunction

    function automatic void pmem_read(input addr_t a, output data_t d);
        pmem_rd_cnt++;
        pmem_last_addr = a;
        d = pmem[pmem_idx(a)];
    endfunction

    function automatic void pmem_write(input addr_t a, input data_t d,
                                       input mask_t m);
        data_t w;
        pmem_wr_cnt++;
        pmem_last_addr = a;
        pmem_last_mask = m;
        w = pmem[pmem_idx(a)];
        for (int i = 0; i < MASK_W; i++) begin
            if (m[i]) w[8*i +: 8] = d[8*i +: 8];
        end
        pmem[pmem_idx(a)] = w;
    endfunction

    function automatic data_t pmem_load(input addr_t a);
        data_t d;
        pmem_read(a, d);
        return d;
    endfunction

    // Environment-side access that does not count as a bridge call
    function automatic void pmem_poke(input addr_t a, input data_t d);
        pmem[pmem_idx(a)] = d;
    endfunction

    function automatic data_t pmem_peek(input addr_t a);
        return pmem[pmem_idx(a)];
    endfunction

endpackage

// File: rtl/dpi_mem_bridge_if.sv
// Request/response bus between the core's memory arbiter (master)
// and the DPI memory bridge (slave).
interface dpi_mem_bridge_if;
    import dpi_mem_bridge_pkg::*;

    logic  req_valid;
    logic  req_ready;
    logic  req_wen;
    addr_t req_addr;
    data_t req_wdata;
    mask_t req_wmask;
    logic  resp_valid;
    logic  resp_ready;
    data_t resp_rdata;
    logic  resp_wr;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask,
        output resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_wr
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask,
        input  resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_wr
    );

endinterface

// File: rtl/dpi_mem_bridge_port.sv
// Owns the physical-memory calls so the bridge FSM stays call-free;
// one call per strobe, read data registered.
module dpi_mem_port
    import dpi_mem_bridge_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  do_rd,
    input  logic  do_wr,
    input  addr_t addr,
    input  data_t wdata,
    input  mask_t wmask,
    output data_t rdata
);

    // Store responses carry zero data, so a write also clears rdata
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (do_rd) begin
            rdata <= pmem_load(word_align(addr));
        end else if (do_wr) begin
            pmem_write(word_align(addr), wdata, wmask);
            rdata <= '0;
        end
    end

endmodule

// File: rtl/dpi_mem_bridge.sv
// Holds each core memory request for LATENCY cycles, performs exactly one
// physical-memory access, then returns the result over a valid/ready response.
module dpi_mem_bridge
    import dpi_mem_bridge_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    dpi_mem_bridge_if.slave   bus,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       accept;
    logic       do_call;

    logic       wen_q;
    addr_t      addr_q;
    data_t      wdata_q;
    mask_t      wmask_q;
    logic       wr_q;
    data_t      rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wen_q   <= bus.req_wen;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                wmask_q <= bus.req_wmask;
            end
            if (do_call) wr_q <= wen_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        do_call = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    do_call = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs depend on state only, never on the inputs
    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_wr    = wr_q;
    assign bus.resp_rdata = rdata;
    assign busy           = (state_q != IDLE);

    dpi_mem_port u_port (
        .clk   (clk),
        .rst   (rst),
        .do_rd (do_call & ~wen_q),
        .do_wr (do_call & wen_q),
        .addr  (addr_q),
        .wdata (wdata_q),
        .wmask (wmask_q),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_dpi_mem_bridge.sv
// Directed bench for dpi_mem_bridge: load, store, backpressure, reset
// mid-wait, back-to-back traffic and a LATENCY=1 instance.
module tb_dpi_mem_bridge;
    import dpi_mem_bridge_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic busy0;
    logic busy1;
    int   checks   = 0;
    int   failures = 0;

    dpi_mem_bridge_if m0 ();
    dpi_mem_bridge_if m1 ();

    dpi_mem_bridge #(.LATENCY(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (m0),
        .busy (busy0)
    );

    dpi_mem_bridge #(.LATENCY(1)) dut1 (
        .clk  (clk),
        .rst  (rst),
        .bus  (m1),
        .busy (busy1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int unsigned rd0;
    int unsigned wr0;
    addr_t       addrs [3];
    data_t       exps  [3];
    data_t       got   [$];
    int          acc   [3];
    int          cyc;
    int          nacc;
    logic        fire;
    logic        hs;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        m0.req_valid = 0; m0.req_wen = 0; m0.req_addr = '0;
        m0.req_wdata = '0; m0.req_wmask = '0; m0.resp_ready = 0;
        m1.req_valid = 0; m1.req_wen = 0; m1.req_addr = '0;
        m1.req_wdata = '0; m1.req_wmask = '0; m1.resp_ready = 0;
        repeat (3) tick();

        check("rst_req_ready", 64'(m0.req_ready), 64'd1);
        check("rst_resp_valid", 64'(m0.resp_valid), 64'd0);
        check("rst_resp_rdata", m0.resp_rdata, 64'd0);
        check("rst_resp_wr", 64'(m0.resp_wr), 64'd0);
        check("rst_busy", 64'(busy0), 64'd0);
        rst = 1'b0;
        tick();

        // Load, unaligned address
        pmem_poke(64'h8000_0008, 64'h1122_3344_5566_7788);
        rd0 = pmem_rd_cnt;
        m0.resp_ready = 1;
        m0.req_valid = 1; m0.req_wen = 0; m0.req_addr = 64'h8000_000C;
        tick();
        m0.req_valid = 0; m0.req_addr = 64'hDEAD_BEEF_0000_0000;
        check("ld_req_ready_low", 64'(m0.req_ready), 64'd0);
        check("ld_busy", 64'(busy0), 64'd1);
        check("ld_rv_n0", 64'(m0.resp_valid), 64'd0);
        tick();
        check("ld_rv_n1", 64'(m0.resp_valid), 64'd0);
        tick();
        check("ld_rv_n2", 64'(m0.resp_valid), 64'd1);
        check("ld_rdata", m0.resp_rdata, 64'h1122_3344_5566_7788);
        check("ld_resp_wr", 64'(m0.resp_wr), 64'd0);
        check("ld_rd_calls", 64'(pmem_rd_cnt - rd0), 64'd1);
        check("ld_call_addr", pmem_last_addr, 64'h8000_0008);
        tick();
        check("ld_done_ready", 64'(m0.req_ready), 64'd1);
        check("ld_done_rv", 64'(m0.resp_valid), 64'd0);
        check("ld_done_busy", 64'(busy0), 64'd0);

        // Store with backpressure; inputs change after accept
        pmem_poke(64'h8000_0010, 64'h0102_0304_0506_0708);
        wr0 = pmem_wr_cnt;
        m0.resp_ready = 0;
        m0.req_valid = 1; m0.req_wen = 1; m0.req_addr = 64'h8000_0010;
        m0.req_wdata = 64'hAABB_CCDD_0000_0000; m0.req_wmask = 8'hF0;
        tick();
        m0.req_valid = 0; m0.req_wdata = '1; m0.req_wmask = 8'hFF;
        m0.req_addr = 64'h8000_0018;
        tick();
        tick();
        check("st_rv", 64'(m0.resp_valid), 64'd1);
        check("st_resp_wr", 64'(m0.resp_wr), 64'd1);
        check("st_rdata", m0.resp_rdata, 64'd0);
        check("st_wr_calls", 64'(pmem_wr_cnt - wr0), 64'd1);
        check("st_call_addr", pmem_last_addr, 64'h8000_0010);
        check("st_call_mask", 64'(pmem_last_mask), 64'hF0);
        check("st_mem_hi", 64'(pmem_peek(64'h8000_0010) >> 32), 64'hAABB_CCDD);
        check("st_mem_lo", 64'(pmem_peek(64'h8000_0010) & 64'hFFFF_FFFF),
              64'h0506_0708);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_rv", 64'(m0.resp_valid), 64'd1);
            check("bp_req_ready", 64'(m0.req_ready), 64'd0);
            check("bp_rdata", m0.resp_rdata, 64'd0);
            check("bp_resp_wr", 64'(m0.resp_wr), 64'd1);
            check("bp_wr_calls", 64'(pmem_wr_cnt - wr0), 64'd1);
        end
        m0.resp_ready = 1;
        tick();
        check("bp_rel_ready", 64'(m0.req_ready), 64'd1);
        check("bp_rel_busy", 64'(busy0), 64'd0);

        // Store with empty mask still calls and responds
        pmem_poke(64'h8000_0018, 64'h5555_AAAA_5555_AAAA);
        wr0 = pmem_wr_cnt;
        m0.req_valid = 1; m0.req_wen = 1; m0.req_addr = 64'h8000_001B;
        m0.req_wdata = '1; m0.req_wmask = 8'h00;
        tick();
        m0.req_valid = 0;
        tick();
        tick();
        check("m0_rv", 64'(m0.resp_valid), 64'd1);
        check("m0_resp_wr", 64'(m0.resp_wr), 64'd1);
        check("m0_wr_calls", 64'(pmem_wr_cnt - wr0), 64'd1);
        check("m0_call_addr", pmem_last_addr, 64'h8000_0018);
        check("m0_mem", pmem_peek(64'h8000_0018), 64'h5555_AAAA_5555_AAAA);
        tick();

        // Reset one cycle after accepting a store
        pmem_poke(64'h8000_0020, 64'h7777);
        wr0 = pmem_wr_cnt;
        m0.req_valid = 1; m0.req_wen = 1; m0.req_addr = 64'h8000_0020;
        m0.req_wdata = 64'h1234; m0.req_wmask = 8'hFF;
        tick();
        m0.req_valid = 0;
        rst = 1'b1;
        #1;
        check("rm_busy", 64'(busy0), 64'd0);
        check("rm_rv", 64'(m0.resp_valid), 64'd0);
        check("rm_ready", 64'(m0.req_ready), 64'd1);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("rm_wr_calls", 64'(pmem_wr_cnt - wr0), 64'd0);
        check("rm_mem", pmem_peek(64'h8000_0020), 64'h7777);
        check("rm_idle", 64'(busy0), 64'd0);
        rd0 = pmem_rd_cnt;
        m0.req_valid = 1; m0.req_wen = 0; m0.req_addr = 64'h8000_0008;
        tick();
        m0.req_valid = 0;
        tick();
        tick();
        check("rm_ld_rv", 64'(m0.resp_valid), 64'd1);
        check("rm_ld_rdata", m0.resp_rdata, 64'h1122_3344_5566_7788);
        check("rm_ld_calls", 64'(pmem_rd_cnt - rd0), 64'd1);
        tick();

        // Back-to-back loads with req_valid held high
        addrs[0] = 64'h8000_0028; exps[0] = 64'hA1A1_0000_0000_00A1;
        addrs[1] = 64'h8000_0030; exps[1] = 64'hB2B2_0000_0000_00B2;
        addrs[2] = 64'h8000_0038; exps[2] = 64'hC3C3_0000_0000_00C3;
        for (int i = 0; i < 3; i++) pmem_poke(addrs[i], exps[i]);
        rd0 = pmem_rd_cnt;
        nacc = 0;
        cyc = 0;
        m0.resp_ready = 1;
        m0.req_valid = 1; m0.req_wen = 0; m0.req_addr = addrs[0];
        while (got.size() < 3 && cyc < 60) begin
            fire = m0.req_valid && m0.req_ready;
            hs = m0.resp_valid && m0.resp_ready;
            if (hs) got.push_back(m0.resp_rdata);
            if (fire) acc[nacc] = cyc;
            tick();
            cyc++;
            if (fire) begin
                nacc++;
                if (nacc < 3) m0.req_addr = addrs[nacc];
                else m0.req_valid = 0;
            end
        end
        check("b2b_resp_cnt", 64'(got.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check("b2b_rdata", (i < got.size()) ? got[i] : 64'd0, exps[i]);
        end
        check("b2b_gap01", 64'(acc[1] - acc[0]), 64'd4);
        check("b2b_gap12", 64'(acc[2] - acc[1]), 64'd4);
        check("b2b_rd_calls", 64'(pmem_rd_cnt - rd0), 64'd3);
        tick();

        // LATENCY=1 instance
        rd0 = pmem_rd_cnt;
        m1.resp_ready = 1;
        m1.req_valid = 1; m1.req_wen = 0; m1.req_addr = 64'h8000_0030;
        tick();
        m1.req_valid = 0;
        check("l1_rv_n0", 64'(m1.resp_valid), 64'd0);
        check("l1_busy", 64'(busy1), 64'd1);
        tick();
        check("l1_rv_n1", 64'(m1.resp_valid), 64'd1);
        check("l1_rdata", m1.resp_rdata, 64'hB2B2_0000_0000_00B2);
        check("l1_rd_calls", 64'(pmem_rd_cnt - rd0), 64'd1);
        tick();
        check("l1_done_ready", 64'(m1.req_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
